mux_rr_arb: RTL and testbench
=============================

MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel.
REQ-002 Parameter NCH, default 32, channel count, legal range 2..32; SELW = clog2(NCH) is derived, not a parameter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mode  input  1  0 = direct select by sel; 1 = round-robin over valid channels.
REQ-006 sel  input  SELW  channel index used in mode 0.
REQ-007 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NCH  per-channel valid.
REQ-009 in_ready  output  NCH  per-channel accept, one-hot or zero, combinational.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_ch  output  SELW  registered index of the channel held in out_data.
REQ-012 out_valid  output  1  output register holds a beat.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 sel_err  output  1  registered; 1-cycle pulse on illegal sel.
REQ-015 xfer_cnt  output  16  count of output handshakes.

Function
REQ-016 Input transfer on channel i occurs when in_valid[i] && in_ready[i] in the same cycle; output transfer occurs when out_valid && out_ready.
REQ-017 load = (!out_valid || out_ready) && candidate exists; in_ready is the one-hot of the candidate gated by load, zero otherwise.
REQ-018 On load, out_data/out_ch take the candidate channel data/index at the next edge and out_valid = 1; latency from input transfer to out_valid is 1 cycle.
REQ-019 Output transfer with no load clears out_valid; simultaneous output transfer and load keep out_valid = 1 with new data (full throughput, one beat per cycle).
REQ-020 When out_valid && !out_ready, out_data/out_ch are held stable and in_ready = 0.
REQ-021 Mode 0: candidate = sel when sel < NCH && in_valid[sel]; otherwise none.
REQ-022 Mode 0, sel >= NCH: no candidate; sel_err pulses high for one cycle per cycle of illegal sel (registered, 1-cycle delay).
REQ-023 Mode 1: candidate = first i with in_valid[i], searching ptr+1, ptr+2, ... with wrap modulo NCH, ending at ptr; no valid → none.
REQ-024 ptr (SELW bits) updates to the granted index on every load in mode 1 only; mode 0 loads leave ptr unchanged.
REQ-025 Mode change takes effect on the next cycle's candidate evaluation; the beat already in out_data is unaffected.
REQ-026 xfer_cnt increments by 1 per output transfer, wraps 0xFFFF -> 0x0000.
REQ-027 sel, mode and in_valid are sampled combinationally each cycle; no internal queueing beyond the single output register.

Reset
REQ-028 rst_n low asynchronously forces out_valid = 0, out_data = 0, out_ch = 0, sel_err = 0, xfer_cnt = 0, ptr = NCH-1 (channel 0 has first round-robin priority).
REQ-029 While rst_n is low, in_ready = 0; a beat in flight at reset is discarded.
REQ-030 Deassertion requires no sync sequence; the first load is possible on the first rising edge after release.

Verification
REQ-031 Mode 0, NCH=32, sel=5, in_valid=all ones, channel i data = i, out_ready=1 -> out_data=5, out_ch=5 one cycle later; in_ready=0x00000020 every cycle.
REQ-032 Mode 1, in_valid=0x0000000B, out_ready=1 from reset -> out_ch sequence 0,1,3,0,1,3; xfer_cnt increments each cycle.
REQ-033 Mode 1, out_ready=0 for 4 cycles after first load -> out_data held, in_ready=0, ptr frozen; on out_ready=1, next grant follows the held channel.
REQ-034 NCH=20, mode 0, sel=25 -> no load, in_ready=0, sel_err=1 for each such cycle (one-cycle delay), out_valid unchanged.
REQ-035 xfer_cnt preset by 65535 transfers, one more transfer -> xfer_cnt=0; rst_n pulsed low mid-stream -> all outputs zero immediately, and after release mode 1 first grants channel 0.

Source files
------------

// File: rtl/mux_rr_arb_if.sv
// Bundle of the channel-side and output-side signals of mux_rr_arb.
// The slave modport is the arbiter's view. The master modport is the view of
// the logic that drives channels and consumes the output.
interface mux_rr_arb_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 32
);
    localparam int SELW = $clog2(NCH);

    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;
    logic [15:0]          xfer_cnt;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid, sel_err, xfer_cnt
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid, sel_err, xfer_cnt
    );
endinterface

// File: rtl/mux_rr_arb.sv
// Channel multiplexer with a single registered output stage.
// In mode 0 the channel comes directly from sel. In mode 1 the valid channels
// are served round-robin. The output register refills in the same cycle it
// drains, so the output can carry one beat per clock.
module mux_rr_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_rr_arb_if.slave   bus
);
    localparam int SELW = $clog2(NCH);

    logic [WIDTH-1:0] chan_data [NCH];

    logic [SELW-1:0]  ptr_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_ch_reg;
    logic             out_valid_reg;
    logic             sel_err_reg;
    logic [15:0]      xfer_cnt_reg;
    logic [15:0]      xfer_cnt_next;

    logic [31:0]      sel_wide;
    logic             sel_legal;
    logic [SELW:0]    rr_idx;
    logic [SELW-1:0]  rr_cand;
    logic             rr_ok;
    logic [SELW-1:0]  cand;
    logic             cand_ok;
    logic             load;
    logic             out_xfer;

    // Unpack channel data and build the one-hot accept from the candidate.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan_data[gi]   = bus.in_data[gi*WIDTH +: WIDTH];
            assign bus.in_ready[gi] = load && (cand == SELW'(gi));
        end
    endgenerate

    // Widen sel so that the legality check stays meaningful when NCH is a power of two.
    assign sel_wide  = 32'(bus.sel);
    assign sel_legal = sel_wide < 32'(NCH);

    // Round-robin search: ptr+1, ptr+2, ... wrapping, and ptr itself is checked last.
    always_comb begin
        rr_ok   = 1'b0;
        rr_cand = '0;
        rr_idx  = '0;
        for (int k = 1; k <= NCH; k++) begin
            rr_idx = {1'b0, ptr_reg} + (SELW+1)'(k);
            if (rr_idx >= (SELW+1)'(NCH)) begin
                rr_idx = rr_idx - (SELW+1)'(NCH);
            end
            if (!rr_ok && bus.in_valid[rr_idx[SELW-1:0]]) begin
                rr_ok   = 1'b1;
                rr_cand = rr_idx[SELW-1:0];
            end
        end
    end

    // Pick the candidate for the current mode. An illegal sel never yields a candidate.
    always_comb begin
        cand    = bus.sel;
        cand_ok = 1'b0;
        if (bus.mode) begin
            cand    = rr_cand;
            cand_ok = rr_ok;
        end else begin
            cand_ok = sel_legal && bus.in_valid[bus.sel];
        end
    end

    // The output register can accept a beat when it is empty or is draining now. Hold off while in reset.
    assign load          = rst_n && (!out_valid_reg || bus.out_ready) && cand_ok;
    assign out_xfer      = out_valid_reg && bus.out_ready;
    assign xfer_cnt_next = out_xfer ? xfer_cnt_reg + 16'd1 : xfer_cnt_reg;

    // Output stage, round-robin pointer, error pulse and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= SELW'(NCH - 1);
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
            xfer_cnt_reg  <= '0;
        end else begin
            if (load) begin
                out_data_reg  <= chan_data[cand];
                out_ch_reg    <= cand;
                out_valid_reg <= 1'b1;
                if (bus.mode) begin
                    ptr_reg <= cand;
                end
            end else if (out_xfer) begin
                out_valid_reg <= 1'b0;
            end
            sel_err_reg  <= !bus.mode && !sel_legal;
            xfer_cnt_reg <= xfer_cnt_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sel_err   = sel_err_reg;
    assign bus.xfer_cnt  = xfer_cnt_reg;
endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb. It uses a 32-channel instance for direct select,
// round-robin, stall, reset and counter wrap. It uses a 20-channel instance for illegal sel.
module tb_mux_rr_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arb_if #(.WIDTH(32), .NCH(32)) b32 ();
    mux_rr_arb_if #(.WIDTH(8),  .NCH(20)) b20 ();

    mux_rr_arb #(.WIDTH(32), .NCH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    mux_rr_arb #(.WIDTH(8),  .NCH(20)) dut20 (.clk(clk), .rst_n(rst_n), .bus(b20.slave));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        b32.mode = 1'b0; b32.sel = '0; b32.in_valid = '0; b32.out_ready = 1'b0;
        b20.mode = 1'b0; b20.sel = '0; b20.in_valid = '0; b20.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) b32.in_data[i*32 +: 32] = 32'(i);
        for (int i = 0; i < 20; i++) b20.in_data[i*8 +: 8] = 8'(i + 16);

        // Reset state, with channels already offering data.
        @(negedge clk);
        b32.in_valid = '1; b32.out_ready = 1'b1; b32.sel = 5'd5;
        #1;
        check("rst_in_ready",  64'(b32.in_ready),  64'h0);
        check("rst_out_valid", 64'(b32.out_valid), 64'h0);
        check("rst_out_data",  64'(b32.out_data),  64'h0);
        check("rst_out_ch",    64'(b32.out_ch),    64'h0);
        check("rst_sel_err",   64'(b32.sel_err),   64'h0);
        check("rst_xfer_cnt",  64'(b32.xfer_cnt),  64'h0);

        // Direct select of channel 5.
        rst_n = 1'b1;
        #1;
        check("m0_in_ready", 64'(b32.in_ready), 64'h20);
        step;
        check("m0_out_data",  64'(b32.out_data),  64'd5);
        check("m0_out_ch",    64'(b32.out_ch),    64'd5);
        check("m0_out_valid", 64'(b32.out_valid), 64'd1);
        check("m0_in_ready2", 64'(b32.in_ready),  64'h20);
        check("m0_cnt0",      64'(b32.xfer_cnt),  64'd0);
        step;
        check("m0_cnt1", 64'(b32.xfer_cnt), 64'd1);

        // Asynchronous reset in the middle of the stream.
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(b32.out_valid), 64'h0);
        check("ar_out_data",  64'(b32.out_data),  64'h0);
        check("ar_xfer_cnt",  64'(b32.xfer_cnt),  64'h0);
        check("ar_in_ready",  64'(b32.in_ready),  64'h0);
        b32.mode = 1'b1; b32.in_valid = 32'h0000_000B;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rr_first_ready", 64'(b32.in_ready), 64'h1);

        // Round-robin over channels 0, 1 and 3.
        for (int k = 0; k < 6; k++) begin
            step;
            check("rr_out_ch",   64'(b32.out_ch),   64'(rr_seq[k]));
            check("rr_out_data", 64'(b32.out_data), 64'(rr_seq[k]));
            check("rr_cnt",      64'(b32.xfer_cnt), 64'(k));
        end

        // Stall for four cycles: the beat is held and no channel is accepted.
        b32.out_ready = 1'b0;
        #1;
        check("st_in_ready", 64'(b32.in_ready), 64'h0);
        repeat (4) begin
            step;
            check("st_out_ch",    64'(b32.out_ch),    64'd3);
            check("st_out_data",  64'(b32.out_data),  64'd3);
            check("st_out_valid", 64'(b32.out_valid), 64'd1);
            check("st_in_ready",  64'(b32.in_ready),  64'h0);
            check("st_cnt",       64'(b32.xfer_cnt),  64'd5);
        end
        b32.out_ready = 1'b1;
        #1;
        check("st_resume_ready", 64'(b32.in_ready), 64'h1);
        step;
        check("st_resume_ch",  64'(b32.out_ch),   64'd0);
        check("st_resume_cnt", 64'(b32.xfer_cnt), 64'd6);

        // A mode 0 load does not move the round-robin pointer.
        b32.mode = 1'b0; b32.sel = 5'd7; b32.in_valid = 32'h0000_008B;
        #1;
        check("mc_in_ready_m0", 64'(b32.in_ready), 64'h80);
        step;
        check("mc_out_ch_m0", 64'(b32.out_ch),   64'd7);
        check("mc_cnt7",      64'(b32.xfer_cnt), 64'd7);
        b32.mode = 1'b1;
        #1;
        check("mc_in_ready_m1", 64'(b32.in_ready), 64'h2);
        step;
        check("mc_out_ch_m1", 64'(b32.out_ch),   64'd1);
        check("mc_cnt8",      64'(b32.xfer_cnt), 64'd8);

        // No valid channels: the register drains and stays empty.
        b32.in_valid = '0;
        #1;
        check("nv_in_ready", 64'(b32.in_ready), 64'h0);
        step;
        check("nv_out_valid", 64'(b32.out_valid), 64'd0);
        check("nv_cnt9",      64'(b32.xfer_cnt),  64'd9);
        step;
        check("nv_out_valid2", 64'(b32.out_valid), 64'd0);
        check("nv_cnt9b",      64'(b32.xfer_cnt),  64'd9);

        // Illegal sel on the 20-channel instance.
        b20.mode = 1'b0; b20.sel = 5'd25; b20.in_valid = '1; b20.out_ready = 1'b0;
        #1;
        check("se_in_ready", 64'(b20.in_ready), 64'h0);
        check("se_no_err_yet", 64'(b20.sel_err), 64'h0);
        step;
        check("se_err1",   64'(b20.sel_err),   64'd1);
        check("se_valid0", 64'(b20.out_valid), 64'd0);
        b20.sel = 5'd3;
        #1;
        check("se_legal_ready", 64'(b20.in_ready), 64'h8);
        step;
        check("se_err0",     64'(b20.sel_err),   64'd0);
        check("se_valid1",   64'(b20.out_valid), 64'd1);
        check("se_out_ch",   64'(b20.out_ch),    64'd3);
        check("se_out_data", 64'(b20.out_data),  64'h13);
        b20.sel = 5'd25;
        #1;
        check("se_in_ready2", 64'(b20.in_ready), 64'h0);
        step;
        check("se_err_a",   64'(b20.sel_err),   64'd1);
        check("se_held_v",  64'(b20.out_valid), 64'd1);
        check("se_held_ch", 64'(b20.out_ch),    64'd3);
        step;
        check("se_err_b",     64'(b20.sel_err),  64'd1);
        check("se_held_data", 64'(b20.out_data), 64'h13);
        b20.sel = 5'd3;
        step;
        check("se_err_clear", 64'(b20.sel_err), 64'd0);

        // Counter wrap with every channel valid at full throughput.
        b32.in_valid = '1;
        step;
        check("wr_first_ch", 64'(b32.out_ch),   64'd2);
        check("wr_cnt_base", 64'(b32.xfer_cnt), 64'd9);
        repeat (65526) @(posedge clk);
        @(negedge clk);
        check("wr_cnt_max", 64'(b32.xfer_cnt), 64'hFFFF);
        check("wr_ch",      64'(b32.out_ch),   64'd24);
        step;
        check("wr_cnt_zero", 64'(b32.xfer_cnt), 64'h0);
        check("wr_ch_next",  64'(b32.out_ch),   64'd25);

        // Final reset pulse: after release, round-robin restarts at channel 0.
        rst_n = 1'b0;
        #1;
        check("fr_out_valid", 64'(b32.out_valid), 64'h0);
        check("fr_out_ch",    64'(b32.out_ch),    64'h0);
        check("fr_xfer_cnt",  64'(b32.xfer_cnt),  64'h0);
        check("fr_in_ready",  64'(b32.in_ready),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fr_ready_ch0", 64'(b32.in_ready), 64'h1);
        step;
        check("fr_out_ch0",   64'(b32.out_ch),    64'd0);
        check("fr_out_valid", 64'(b32.out_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
